// File: rtl/synth_pkg.sv
// Shared definitions for the synthesizer oscillator family.
// Provides the default phase/sample widths and the parameter set carried
// between the request shadow and the active copy of an oscillator.
package synth_pkg;

    localparam int unsigned PHASE_W_DEF = 16;
    localparam int unsigned OUT_W_DEF   = 8;

    // One complete oscillator setting: pitch, duty threshold, level, polarity
    typedef struct packed {
        logic [PHASE_W_DEF-1:0] inc;
        logic [PHASE_W_DEF-1:0] duty;
        logic [OUT_W_DEF-1:0]   amp;
        logic                   pol;
    } param_set_t;

endpackage

// File: rtl/phase_acc.sv
// Phase accumulator with run enable, synchronous clear and carry-out.
// Ports:
//   clk, rst  - clock, async active-low reset
//   en        - advance phase by inc each clk
//   clr       - force phase to 0 (takes priority over en)
//   inc       - phase step per clk
//   phase     - current (registered) phase
//   carry_c   - combinational: the step taken this cycle wraps modulo 2^W
module phase_acc #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         clr,
    input  logic [W-1:0] inc,
    output logic [W-1:0] phase,
    output logic         carry_c
);

    logic [W:0] sum_c;

    assign sum_c   = {1'b0, phase} + {1'b0, inc};
    // Only a step that is actually taken can wrap
    assign carry_c = en & ~clr & sum_c[W];

    // Phase register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            phase <= '0;
        end else if (clr) begin
            phase <= '0;
        end else if (en) begin
            phase <= sum_c[W-1:0];
        end
    end

endmodule

// File: rtl/pulse_wave_gen.sv
// Square/pulse oscillator with glitch-free parameter updates.
// A request captures inc/duty/amp/pol into a pending shadow; the shadow is
// promoted to the active set on period wrap while running, or at once while
// idle, so a period is never built from a mix of old and new settings.
// Ports:
//   clk, rst   - clock, async active-low reset
//   en         - oscillator run enable (0 holds phase at 0, output 0)
//   inc        - tuning word, phase step per clk
//   duty       - high-time threshold as a fraction of 2^PHASE_W
//   amp        - level driven during the high portion
//   pol        - 0 high first then low, 1 inverted
//   upd_req    - one-cycle request to capture the inputs above
//   upd_ack    - one-cycle pulse when a captured set becomes active
//   wave       - registered output sample
//   sync       - one-cycle pulse on period wrap
module pulse_wave_gen
    import synth_pkg::*;
#(
    parameter int unsigned PHASE_W = PHASE_W_DEF,
    parameter int unsigned OUT_W   = OUT_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic [PHASE_W-1:0] inc,
    input  logic [PHASE_W-1:0] duty,
    input  logic [OUT_W-1:0]   amp,
    input  logic               pol,
    input  logic               upd_req,
    output logic               upd_ack,
    output logic [OUT_W-1:0]   wave,
    output logic               sync
);

    // Same layout as param_set_t, sized to this instance's widths
    typedef struct packed {
        logic [PHASE_W-1:0] inc;
        logic [PHASE_W-1:0] duty;
        logic [OUT_W-1:0]   amp;
        logic               pol;
    } set_t;

    set_t               act_q;
    set_t               pend_q;
    set_t               cap_c;
    set_t               apply_set_c;
    logic               pend_v_q;
    logic               pend_v_d;
    logic               apply_c;
    logic               clr_c;
    logic               wrap_c;
    logic               hi_c;
    logic [PHASE_W-1:0] phase;

    assign cap_c = '{inc: inc, duty: duty, amp: amp, pol: pol};
    assign clr_c = ~en;

    phase_acc #(
        .W (PHASE_W)
    ) u_phase_acc (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .clr     (clr_c),
        .inc     (act_q.inc),
        .phase   (phase),
        .carry_c (wrap_c)
    );

    // High/low decision on the pre-update phase
    assign hi_c = (phase < act_q.duty) ^ act_q.pol;

    // Promotion of a set into the active registers.
    // Idle: a request in this cycle bypasses the shadow so the ack follows
    // the request by one clk. Running: only the shadow as it stood before
    // this cycle's capture is promoted, and only on wrap.
    always_comb begin
        apply_c     = 1'b0;
        apply_set_c = pend_q;
        pend_v_d    = pend_v_q;
        if (!en) begin
            if (upd_req) begin
                apply_c     = 1'b1;
                apply_set_c = cap_c;
            end else if (pend_v_q) begin
                apply_c = 1'b1;
            end
            pend_v_d = 1'b0;
        end else begin
            if (wrap_c && pend_v_q) begin
                apply_c  = 1'b1;
                pend_v_d = 1'b0;
            end
            if (upd_req) begin
                pend_v_d = 1'b1;
            end
        end
    end

    // Shadow, active set and output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            act_q    <= '0;
            pend_q   <= '0;
            pend_v_q <= 1'b0;
            upd_ack  <= 1'b0;
            wave     <= '0;
            sync     <= 1'b0;
        end else begin
            if (upd_req) begin
                pend_q <= cap_c;
            end
            pend_v_q <= pend_v_d;
            if (apply_c) begin
                act_q <= apply_set_c;
            end
            upd_ack <= apply_c;
            wave    <= (en && hi_c) ? act_q.amp : '0;
            sync    <= wrap_c;
        end
    end

endmodule

// File: tb/tb_pulse_wave_gen.sv
// Directed self-checking bench for pulse_wave_gen (PHASE_W=16, OUT_W=8).
module tb_pulse_wave_gen;

    logic        clk;
    logic        rst;
    logic        en;
    logic [15:0] inc;
    logic [15:0] duty;
    logic [7:0]  amp;
    logic        pol;
    logic        upd_req;
    logic        upd_ack;
    logic [7:0]  wave;
    logic        sync;

    int checks = 0;
    int errors = 0;

    // Results of the most recent measure() window
    int m_nz;
    int m_hit;
    int m_sync;
    int m_last_sync;
    int m_ack;
    int m_last_ack;

    pulse_wave_gen #(
        .PHASE_W (16),
        .OUT_W   (8)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .inc     (inc),
        .duty    (duty),
        .amp     (amp),
        .pol     (pol),
        .upd_req (upd_req),
        .upd_ack (upd_ack),
        .wave    (wave),
        .sync    (sync)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One-cycle update request with the given set
    task automatic load(input logic [15:0] i, input logic [15:0] d,
                        input logic [7:0] a, input logic p);
        inc     = i;
        duty    = d;
        amp     = a;
        pol     = p;
        upd_req = 1'b1;
        step();
        upd_req = 1'b0;
    endtask

    // Run n clks, tallying nonzero samples, samples equal to tgt, syncs and acks
    task automatic measure(input int n, input logic [7:0] tgt);
        m_nz = 0; m_hit = 0; m_sync = 0; m_last_sync = 0; m_ack = 0; m_last_ack = 0;
        for (int k = 1; k <= n; k++) begin
            step();
            if (wave != 8'h00) m_nz++;
            if (wave == tgt)   m_hit++;
            if (sync)    begin m_sync++; m_last_sync = k; end
            if (upd_ack) begin m_ack++;  m_last_ack  = k; end
        end
    endtask

    initial begin
        rst = 1'b0; en = 1'b0; inc = '0; duty = '0; amp = '0; pol = 1'b0; upd_req = 1'b0;
        repeat (3) step();
        check("rst_wave", 32'(wave), 32'h0);
        check("rst_sync", 32'(sync), 32'h0);
        check("rst_ack", 32'(upd_ack), 32'h0);
        rst = 1'b1;
        step();

        // Basic square, loaded while idle
        load(16'd256, 16'h8000, 8'hFF, 1'b0);
        check("idle_ack", 32'(upd_ack), 32'h1);
        en = 1'b1;
        step();
        check("sq_first_wave", 32'(wave), 32'hFF);
        check("sq_ack_clear", 32'(upd_ack), 32'h0);
        measure(255, 8'hFF);
        check("sq_p1_high", 32'(m_nz), 32'd127);
        check("sq_p1_sync_at", 32'(m_last_sync), 32'd255);
        measure(256, 8'hFF);
        check("sq_p2_high", 32'(m_nz), 32'd128);
        check("sq_p2_syncs", 32'(m_sync), 32'd1);
        check("sq_p2_sync_at", 32'(m_last_sync), 32'd256);

        // Pulse width, both polarities
        en = 1'b0;
        load(16'd256, 16'h4000, 8'hFF, 1'b0);
        check("pw_ack", 32'(upd_ack), 32'h1);
        check("pw_wave_off", 32'(wave), 32'h0);
        en = 1'b1;
        measure(256, 8'hFF);
        check("pw_high", 32'(m_nz), 32'd64);
        check("pw_syncs", 32'(m_sync), 32'd1);
        en = 1'b0;
        load(16'd256, 16'h4000, 8'hFF, 1'b1);
        en = 1'b1;
        measure(256, 8'hFF);
        check("pw_inv_high", 32'(m_nz), 32'd192);

        // Glitch-free update mid-period
        en = 1'b0;
        load(16'd256, 16'h8000, 8'hFF, 1'b0);
        en = 1'b1;
        measure(100, 8'hFF);
        check("gf_pre_high", 32'(m_nz), 32'd100);
        load(16'd512, 16'h8000, 8'hFF, 1'b0);
        check("gf_no_early_ack", 32'(upd_ack), 32'h0);
        measure(155, 8'hFF);
        check("gf_old_high", 32'(m_nz), 32'd27);
        check("gf_sync_at", 32'(m_last_sync), 32'd155);
        check("gf_acks", 32'(m_ack), 32'd1);
        check("gf_ack_at", 32'(m_last_ack), 32'd155);
        measure(128, 8'hFF);
        check("gf_new_sync_at", 32'(m_last_sync), 32'd128);
        check("gf_new_syncs", 32'(m_sync), 32'd1);
        check("gf_new_high", 32'(m_nz), 32'd64);

        // Back-to-back requests: latest wins, single ack
        measure(10, 8'hFF);
        load(16'd512, 16'h8000, 8'h40, 1'b0);
        measure(20, 8'hFF);
        load(16'd512, 16'h8000, 8'h80, 1'b0);
        check("bb_no_early_ack", 32'(upd_ack), 32'h0);
        measure(96, 8'h40);
        check("bb_acks", 32'(m_ack), 32'd1);
        check("bb_ack_at", 32'(m_last_ack), 32'd96);
        check("bb_no_40_old", 32'(m_hit), 32'd0);
        measure(128, 8'h80);
        check("bb_amp80", 32'(m_hit), 32'd64);
        check("bb_no_second_ack", 32'(m_ack), 32'd0);

        // Edge: duty=0 keeps wave at 0
        en = 1'b0;
        load(16'd256, 16'h0000, 8'hFF, 1'b0);
        en = 1'b1;
        measure(300, 8'hFF);
        check("duty0_nz", 32'(m_nz), 32'd0);
        check("duty0_syncs", 32'(m_sync), 32'd1);

        // Edge: inc=0 freezes phase, no sync, pending held
        en = 1'b0;
        load(16'd0, 16'h8000, 8'hFF, 1'b0);
        en = 1'b1;
        measure(1000, 8'hFF);
        check("inc0_syncs", 32'(m_sync), 32'd0);
        check("inc0_static_high", 32'(m_hit), 32'd1000);
        load(16'd0, 16'h8000, 8'h40, 1'b0);
        measure(50, 8'h40);
        check("inc0_no_ack", 32'(m_ack), 32'd0);
        check("inc0_no_apply", 32'(m_hit), 32'd0);

        // Reset mid-operation with an update pending
        #2;
        rst = 1'b0;
        #1;
        check("mid_rst_wave", 32'(wave), 32'h0);
        check("mid_rst_sync", 32'(sync), 32'h0);
        check("mid_rst_ack", 32'(upd_ack), 32'h0);
        step();
        rst = 1'b1;
        measure(50, 8'hFF);
        check("post_rst_nz", 32'(m_nz), 32'd0);
        check("post_rst_no_ack", 32'(m_ack), 32'd0);
        en = 1'b0;
        load(16'd256, 16'h8000, 8'hFF, 1'b0);
        check("post_rst_load_ack", 32'(upd_ack), 32'h1);
        en = 1'b1;
        step();
        check("post_rst_wave", 32'(wave), 32'hFF);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
